tl_rr_arbiter: RTL and testbench

TL_RR_ARBITER -- requirements
Module: tl_rr_arbiter

---
 rtl/tl_pkg.sv | 14 +
 rtl/tl_rr_arbiter_rr_pick.sv | 33 +++
 rtl/tl_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_tl_rr_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types for the tile-link style arbitration blocks.
package tl_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index width for an N-entry selector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo N.
module rr_pick
  import tl_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] gnt_o,
  output logic          any_req_o
);

  // Two descending passes: the later pass (indices above ptr) overrides the
  // wrapped pass, and within a pass the lowest index is written last.
  always_comb begin
    gnt_o     = '0;
    any_req_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (i <= int'(ptr_i))) begin
        gnt_o     = PW'(i);
        any_req_o = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (i > int'(ptr_i))) begin
        gnt_o     = PW'(i);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_rr_arbiter.sv
// N-to-1 message-locked round-robin arbiter with a single registered output stage.
module tl_rr_arbiter
  import tl_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N-1:0]    m_vld_i,
  input  logic [N*DW-1:0] m_data_i,
  input  logic [N-1:0]    m_last_i,
  output logic [N-1:0]    m_busy_o,
  output logic [DW-1:0]   s_data_o,
  output logic            s_last_o,
  output logic            s_vld_o,
  input  logic            s_busy_i
);

  localparam int             PW      = idx_w(N);
  localparam logic [PW-1:0]  PTR_RST = PW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] s_data_q, s_data_d;
  logic          s_last_q, s_last_d;
  logic          s_vld_q, s_vld_d;

  logic [PW-1:0] pick_idx;
  logic          any_req;
  logic [PW-1:0] sel_idx;
  logic          sel_vld;
  logic          sel_owned;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic          load_en;
  logic [DW-1:0] data_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign data_arr[gi] = m_data_i[gi*DW +: DW];
  end

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i     (m_vld_i),
    .ptr_i     (ptr_q),
    .gnt_o     (pick_idx),
    .any_req_o (any_req)
  );

  assign load_en = !s_vld_q || !s_busy_i;

  // While locked the owner keeps its slot even with no beat to offer.
  always_comb begin
    sel_idx   = pick_idx;
    sel_vld   = any_req;
    sel_owned = any_req;
    if (state_q == LOCKED) begin
      sel_idx   = gnt_q;
      sel_vld   = m_vld_i[gnt_q];
      sel_owned = 1'b1;
    end
    sel_data = data_arr[sel_idx];
    sel_last = m_last_i[sel_idx];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_busy
    assign m_busy_o[gi] = reset_i || !(load_en && sel_owned && (sel_idx == PW'(gi)));
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    s_data_d = s_data_q;
    s_last_d = s_last_q;
    s_vld_d  = s_vld_q;
    if (load_en) begin
      s_vld_d = 1'b0;
      if (sel_vld) begin
        s_vld_d  = 1'b1;
        s_data_d = sel_data;
        s_last_d = sel_last;
        if (state_q == IDLE) begin
          ptr_d   = sel_idx;
          gnt_d   = sel_idx;
          state_d = sel_last ? IDLE : LOCKED;
        end else if (sel_last) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= PTR_RST;
      s_data_q <= '0;
      s_last_q <= 1'b0;
      s_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      s_data_q <= s_data_d;
      s_last_q <= s_last_d;
      s_vld_q  <= s_vld_d;
    end
  end

  assign s_data_o = s_data_q;
  assign s_last_o = s_last_q;
  assign s_vld_o  = s_vld_q;

endmodule

// File: tb/tb_tl_rr_arbiter.sv
// Self-checking bench for tl_rr_arbiter: directed scenarios plus a random run against a behavioural model.
`timescale 1ns/1ps
module tb_tl_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=2 instance
  logic        rst = 1'b1;
  logic [1:0]  vld = '0, last = '0;
  logic [15:0] data = '0;
  logic [1:0]  busy;
  logic [7:0]  s_data;
  logic        s_last, s_vld;
  logic        s_busy = 1'b0;

  // N=3 instance
  logic        rst3 = 1'b1;
  logic [2:0]  vld3 = '0, last3 = '0;
  logic [23:0] data3 = '0;
  logic [2:0]  busy3;
  logic [7:0]  s_data3;
  logic        s_last3, s_vld3;
  logic        s_busy3 = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cnt5c   = 0;

  tl_rr_arbiter #(.N(2), .DW(8)) u_dut (
    .clk_i(clk), .reset_i(rst), .m_vld_i(vld), .m_data_i(data), .m_last_i(last),
    .m_busy_o(busy), .s_data_o(s_data), .s_last_o(s_last), .s_vld_o(s_vld), .s_busy_i(s_busy)
  );

  tl_rr_arbiter #(.N(3), .DW(8)) u_dut3 (
    .clk_i(clk), .reset_i(rst3), .m_vld_i(vld3), .m_data_i(data3), .m_last_i(last3),
    .m_busy_o(busy3), .s_data_o(s_data3), .s_last_o(s_last3), .s_vld_o(s_vld3), .s_busy_i(s_busy3)
  );

  // Counts deliveries of the 0x5C beat to prove it leaves exactly once.
  always @(posedge clk)
    if (!rst && s_vld && !s_busy && s_data == 8'h5C) cnt5c <= cnt5c + 1;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vld = '0; last = '0; data = '0; s_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; vld = 2'b11; last = 2'b11; data = 16'hB1A0; s_busy = 1'b0;
    #1;
    vec_cnt++;
    if (busy !== 2'b11 || s_vld !== 1'b0 || s_data !== 8'h00 || s_last !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: busy=%b vld=%b data=%h last=%b, want busy=11 vld=0 data=00 last=0",
               busy, s_vld, s_data, s_last);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (busy !== 2'b10) begin
      err_cnt++; $display("FAIL reset_first_grant_busy: got %b want 10", busy);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (s_vld !== 1'b1 || s_data !== 8'hA0) begin
      err_cnt++; $display("FAIL reset_first_beat: vld=%b data=%h want vld=1 data=a0", s_vld, s_data);
    end
    $display("test_reset done");
  endtask

  task automatic test_alternate();
    do_reset();
    vld = 2'b11; last = 2'b11; data = 16'hB1A0;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] eb;
      logic [7:0] ed;
      eb = (k % 2 == 0) ? 2'b10 : 2'b01;
      ed = (k % 2 == 0) ? 8'hA0 : 8'hB1;
      #1;
      vec_cnt++;
      if (busy !== eb) begin
        err_cnt++; $display("FAIL alternate_busy[%0d]: got %b want %b", k, busy, eb);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (s_vld !== 1'b1 || s_data !== ed) begin
        err_cnt++; $display("FAIL alternate_beat[%0d]: vld=%b data=%h want vld=1 data=%h", k, s_vld, s_data, ed);
      end
      $display("alternate beat %0d data=%h", k, s_data);
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    logic [1:0]  tv [4] = '{2'b11, 2'b11, 2'b11, 2'b10};
    logic [1:0]  tl [4] = '{2'b10, 2'b10, 2'b11, 2'b10};
    logic [15:0] td [4] = '{16'hAA11, 16'hAA22, 16'hAA33, 16'hAA00};
    logic [1:0]  eb [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    logic [7:0]  ed [4] = '{8'h11, 8'h22, 8'h33, 8'hAA};
    logic        el [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      vld = tv[k]; last = tl[k]; data = td[k];
      #1;
      vec_cnt++;
      if (busy !== eb[k]) begin
        err_cnt++; $display("FAIL lock_busy[%0d]: got %b want %b", k, busy, eb[k]);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (s_vld !== 1'b1 || s_data !== ed[k] || s_last !== el[k]) begin
        err_cnt++;
        $display("FAIL lock_beat[%0d]: vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                 k, s_vld, s_data, s_last, ed[k], el[k]);
      end
      $display("lock beat %0d data=%h last=%b", k, s_data, s_last);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cnt5c = 0;
    vld = 2'b01; last = 2'b01; data = 16'h005C;
    @(posedge clk); #1;
    vec_cnt++;
    if (s_vld !== 1'b1 || s_data !== 8'h5C) begin
      err_cnt++; $display("FAIL bp_load: vld=%b data=%h want vld=1 data=5c", s_vld, s_data);
    end
    @(negedge clk);
    vld = 2'b10; last = 2'b10; data = 16'h7700; s_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec_cnt++;
      if (busy !== 2'b11) begin
        err_cnt++; $display("FAIL bp_busy_held[%0d]: got %b want 11", k, busy);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (s_vld !== 1'b1 || s_data !== 8'h5C) begin
        err_cnt++; $display("FAIL bp_hold[%0d]: vld=%b data=%h want vld=1 data=5c", k, s_vld, s_data);
      end
      $display("backpressure cycle %0d data=%h", k, s_data);
      @(negedge clk);
    end
    s_busy = 1'b0;
    #1;
    vec_cnt++;
    if (busy !== 2'b01) begin
      err_cnt++; $display("FAIL bp_release_busy: got %b want 01", busy);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (s_vld !== 1'b1 || s_data !== 8'h77) begin
      err_cnt++; $display("FAIL bp_next_beat: vld=%b data=%h want vld=1 data=77", s_vld, s_data);
    end
    @(negedge clk);
    vld = 2'b00;
    @(posedge clk); #1;
    vec_cnt++;
    if (cnt5c !== 1 || s_vld !== 1'b0) begin
      err_cnt++; $display("FAIL bp_once: deliveries=%0d vld=%b want deliveries=1 vld=0", cnt5c, s_vld);
    end
    @(negedge clk);
  endtask

  task automatic test_bubble();
    logic [1:0]  tv [6] = '{2'b01, 2'b11, 2'b01, 2'b01, 2'b11, 2'b01};
    logic [1:0]  tl [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01};
    logic [15:0] td [6] = '{16'h0001, 16'hC102, 16'h0002, 16'h0002, 16'hC202, 16'h0002};
    logic [1:0]  eb [6] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic        ev [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  ed [6] = '{8'h01, 8'hC1, 8'hC1, 8'hC1, 8'hC2, 8'h02};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      vld = tv[k]; last = tl[k]; data = td[k];
      #1;
      vec_cnt++;
      if (busy !== eb[k]) begin
        err_cnt++; $display("FAIL bubble_busy[%0d]: got %b want %b", k, busy, eb[k]);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (s_vld !== ev[k] || s_data !== ed[k]) begin
        err_cnt++;
        $display("FAIL bubble_out[%0d]: vld=%b data=%h want vld=%b data=%h", k, s_vld, s_data, ev[k], ed[k]);
      end
      $display("bubble cycle %0d vld=%b data=%h", k, s_vld, s_data);
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    vld = 2'b01; last = 2'b00; data = 16'h0031;
    @(posedge clk); #1;
    vec_cnt++;
    if (s_vld !== 1'b1 || s_data !== 8'h31) begin
      err_cnt++; $display("FAIL areset_pre: vld=%b data=%h want vld=1 data=31", s_vld, s_data);
    end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (s_vld !== 1'b0 || busy !== 2'b11 || s_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL areset_immediate: vld=%b busy=%b data=%h want vld=0 busy=11 data=00", s_vld, busy, s_data);
    end
    @(negedge clk);
    rst = 1'b0; vld = 2'b11; last = 2'b11; data = 16'h4241;
    #1;
    vec_cnt++;
    if (busy !== 2'b10) begin
      err_cnt++; $display("FAIL areset_m0_first_busy: got %b want 10", busy);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (s_vld !== 1'b1 || s_data !== 8'h41) begin
      err_cnt++; $display("FAIL areset_m0_first_beat: vld=%b data=%h want vld=1 data=41", s_vld, s_data);
    end
    $display("async reset recovered data=%h", s_data);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst3 = 1'b1; vld3 = '0;
    @(negedge clk);
    rst3 = 1'b0; vld3 = 3'b111; last3 = 3'b111; data3 = 24'h323130;
    for (int k = 0; k < 4; k++) begin
      int idx;
      logic [2:0] eb;
      idx = k % 3;
      eb = 3'b111;
      eb[idx] = 1'b0;
      #1;
      vec_cnt++;
      if (busy3 !== eb) begin
        err_cnt++; $display("FAIL wrap_busy[%0d]: got %b want %b", k, busy3, eb);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (s_vld3 !== 1'b1 || s_data3 !== 8'(8'h30 + idx)) begin
        err_cnt++;
        $display("FAIL wrap_beat[%0d]: vld=%b data=%h want vld=1 data=%h", k, s_vld3, s_data3, 8'(8'h30 + idx));
      end
      $display("wrap grant %0d data=%h", k, s_data3);
      @(negedge clk);
    end
  endtask

  // Model: owner of an open message (-1 when none), last winner, and the output register.
  task automatic test_random();
    int         owner = -1;
    int         lastw = 1;
    logic       mvld = 1'b0;
    logic [7:0] mdata = '0;
    logic       mlast = 1'b0;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic       load;
      int         cand;
      logic [1:0] eb;
      vld    = 2'($urandom_range(0, 3));
      last   = 2'($urandom_range(0, 3));
      data   = 16'($urandom);
      s_busy = ($urandom_range(0, 9) < 3);
      load = !mvld || !s_busy;
      cand = -1;
      if (owner >= 0) begin
        if (vld[owner]) cand = owner;
      end else begin
        for (int k = 1; k <= 2; k++) begin
          int i;
          i = (lastw + k) % 2;
          if (cand < 0 && vld[i]) cand = i;
        end
      end
      eb = 2'b11;
      if (load) begin
        if (owner >= 0) eb[owner] = 1'b0;
        else if (cand >= 0) eb[cand] = 1'b0;
      end
      #1;
      vec_cnt++;
      if (busy !== eb) begin
        err_cnt++; $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, eb);
      end
      @(posedge clk);
      if (load) begin
        if (cand >= 0) begin
          mdata = data[cand*8 +: 8];
          mlast = last[cand];
          mvld  = 1'b1;
          if (owner < 0) lastw = cand;
          owner = last[cand] ? -1 : cand;
        end else begin
          mvld = 1'b0;
        end
      end
      #1;
      vec_cnt++;
      if (s_vld !== mvld || s_data !== mdata || s_last !== mlast) begin
        err_cnt++;
        $display("FAIL rand_out[%0d]: vld=%b data=%h last=%b want vld=%b data=%h last=%b",
                 n, s_vld, s_data, s_last, mvld, mdata, mlast);
      end
      $display("rand %0d vld=%b busy_in=%b -> m_busy=%b s_vld=%b s_data=%h", n, vld, s_busy, busy, s_vld, s_data);
      @(negedge clk);
    end
    s_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_alternate();
    test_lock();
    test_backpressure();
    test_bubble();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
